// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the fetch-side PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    StHold,
    StRun,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    SelSeq,
    SelBr,
    SelJ,
    SelJr
  } next_sel_e;

  localparam logic [31:0] DefResetVector = 32'h0040_0000;
  localparam logic [31:0] DefTrapVector  = 32'h8000_0180;
  localparam int unsigned HoldCntW       = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch control bundle between the decode/branch side and the PC sequencer.
interface pc_sequencer_if;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] pc_branch;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        trap;
  logic [31:0] epc;

  modport master (
    output imem_ready, branch_taken, pc_branch, jump, jump_index, jr, jr_target,
    input  pc, pc_plus4, fetch_valid, trap, epc
  );

  modport slave (
    input  imem_ready, branch_taken, pc_branch, jump, jump_index, jr, jr_target,
    output pc, pc_plus4, fetch_valid, trap, epc
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority select (jr > jump > branch > sequential) with
// misalignment detect on the chosen target.
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] pc_branch_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] jr_target_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        jr_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  next_sel_e sel;

  always_comb begin
    sel = SelSeq;
    if (jr_i) begin
      sel = SelJr;
    end else if (jump_i) begin
      sel = SelJ;
    end else if (branch_taken_i) begin
      sel = SelBr;
    end
  end

  always_comb begin
    next_pc_o = pc_plus4_i;
    unique case (sel)
      SelSeq: next_pc_o = pc_plus4_i;
      SelBr:  next_pc_o = pc_branch_i;
      SelJ:   next_pc_o = {pc_plus4_i[31:28], jump_index_i, 2'b00};
      SelJr:  next_pc_o = jr_target_i;
    endcase
  end

  assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: post-reset hold, stall on imem_ready, redirect on
// accept, and a one-cycle trap to a fixed vector for misaligned targets.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DefResetVector,
  parameter logic [31:0] TRAP_VECTOR  = DefTrapVector,
  parameter int unsigned HOLD_CYCLES  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave seq_io
);

  localparam logic [HoldCntW-1:0] HoldLast = HoldCntW'(HOLD_CYCLES - 1);

  state_e              state_q;
  logic [HoldCntW-1:0] hold_cnt_q;
  logic [31:0]         pc_q;
  logic [31:0]         epc_q;
  logic                fetch_valid_q;
  logic                trap_q;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next_sel u_next_sel (
    .pc_plus4_i    (pc_plus4),
    .pc_branch_i   (seq_io.pc_branch),
    .jump_index_i  (seq_io.jump_index),
    .jr_target_i   (seq_io.jr_target),
    .branch_taken_i(seq_io.branch_taken),
    .jump_i        (seq_io.jump),
    .jr_i          (seq_io.jr),
    .next_pc_o     (next_pc),
    .misaligned_o  (misaligned)
  );

  // fetch_valid_q/trap_q are updated alongside state_q so they always match it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHold;
      hold_cnt_q    <= '0;
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      fetch_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_q       <= StRun;
            fetch_valid_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (fetch_valid_q && seq_io.imem_ready) begin
            if (misaligned) begin
              state_q       <= StTrap;
              epc_q         <= pc_q;
              fetch_valid_q <= 1'b0;
              trap_q        <= 1'b1;
            end else begin
              pc_q <= next_pc;
            end
          end
        end
        StTrap: begin
          state_q       <= StRun;
          pc_q          <= TRAP_VECTOR;
          fetch_valid_q <= 1'b1;
          trap_q        <= 1'b0;
        end
        default: begin
          state_q       <= StHold;
          hold_cnt_q    <= '0;
          fetch_valid_q <= 1'b0;
          trap_q        <= 1'b0;
        end
      endcase
    end
  end

  assign seq_io.pc          = pc_q;
  assign seq_io.pc_plus4    = pc_plus4;
  assign seq_io.fetch_valid = fetch_valid_q;
  assign seq_io.trap        = trap_q;
  assign seq_io.epc         = epc_q;

endmodule
